// File: rtl/stb_trace_core.sv
// stb_trace_core
// Circular trace/stream buffer shared between two modes.
//   Trace mode : samples from the FPGA side are captured around a trigger
//                and then unloaded oldest-first through a ready/valid port.
//   Stream mode: the memory is a FIFO from the system-side write port to the
//                FPGA-side trace output (popped with i_trace_valid).
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_mode, i_arm, i_disarm   mode select (latched on arm), start, abort
//   i_trig_delay              post-trigger sample count, sampled on trigger
//   i_trace_valid, i_trace    FPGA sample strobe/data (pop strobe in stream)
//   i_trig                    trigger, honoured only while armed
//   o_trace, o_trig           daisy-chained sample / popped word and flag
//   i_read_ready, o_read_valid, o_read_data    trace readout port
//   i_write_valid, o_write_ready, i_write_data stream write port
//   o_fill                    number of valid entries, 0..DEPTH
module stb_trace_core #(
    parameter  int TRACE_WIDTH = 8,
    parameter  int DEPTH       = 256,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_mode,
    input  logic                   i_arm,
    input  logic                   i_disarm,
    input  logic [ADDR_W-1:0]      i_trig_delay,
    input  logic                   i_trace_valid,
    input  logic [TRACE_WIDTH-1:0] i_trace,
    input  logic                   i_trig,
    output logic [TRACE_WIDTH-1:0] o_trace,
    output logic                   o_trig,
    input  logic                   i_read_ready,
    output logic                   o_read_valid,
    output logic [TRACE_WIDTH-1:0] o_read_data,
    input  logic                   i_write_valid,
    output logic                   o_write_ready,
    input  logic [TRACE_WIDTH-1:0] i_write_data,
    output logic [ADDR_W:0]        o_fill
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_POST,
        ST_DONE,
        ST_STREAM
    } state_t;

    localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [TRACE_WIDTH-1:0] r_mem [DEPTH];

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_wptr;
    logic [ADDR_W-1:0]      r_rptr;
    logic [ADDR_W:0]        r_fill;
    logic [ADDR_W-1:0]      r_dcnt;
    logic [TRACE_WIDTH-1:0] r_traceOut;
    logic                   r_popValid;

    state_t                 w_stateNext;
    logic [ADDR_W-1:0]      w_wptrNext;
    logic [ADDR_W-1:0]      w_rptrNext;
    logic [ADDR_W:0]        w_fillNext;
    logic [ADDR_W-1:0]      w_dcntNext;
    logic [TRACE_WIDTH-1:0] w_traceNext;
    logic                   w_popValidNext;
    logic                   w_memWe;
    logic [TRACE_WIDTH-1:0] w_memData;
    logic                   w_push;
    logic                   w_pop;
    logic [TRACE_WIDTH-1:0] w_memRdData;

    assign w_memRdData = r_mem[r_rptr];

    // Next-state logic. Disarm wins over everything; arm is only looked at
    // in IDLE/DONE, so a trigger coinciding with arm never reaches ARMED.
    always_comb begin
        w_stateNext    = r_state;
        w_wptrNext     = r_wptr;
        w_rptrNext     = r_rptr;
        w_fillNext     = r_fill;
        w_dcntNext     = r_dcnt;
        w_traceNext    = (r_state == ST_STREAM) ? r_traceOut : i_trace;
        w_popValidNext = 1'b0;
        w_memWe        = 1'b0;
        w_memData      = i_trace;
        w_push         = 1'b0;
        w_pop          = 1'b0;

        if (i_disarm) begin
            w_stateNext = ST_IDLE;
            w_wptrNext  = '0;
            w_rptrNext  = '0;
            w_fillNext  = '0;
            w_dcntNext  = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        w_wptrNext  = '0;
                        w_rptrNext  = '0;
                        w_fillNext  = '0;
                        w_stateNext = i_mode ? ST_STREAM : ST_ARMED;
                    end
                end
                ST_ARMED, ST_POST: begin
                    if (i_trace_valid) begin
                        w_memWe    = 1'b1;
                        w_wptrNext = r_wptr + PTR_ONE;
                        if (r_fill != FILL_FULL) begin
                            w_fillNext = r_fill + FILL_ONE;
                        end
                    end
                    if (r_state == ST_ARMED) begin
                        if (i_trig) begin
                            w_dcntNext  = i_trig_delay;
                            w_stateNext = (i_trig_delay == '0) ? ST_DONE : ST_POST;
                        end
                    end else if (i_trace_valid) begin
                        w_dcntNext = r_dcnt - PTR_ONE;
                        if (r_dcnt == PTR_ONE) begin
                            w_stateNext = ST_DONE;
                        end
                    end
                    // Once the buffer has wrapped, the write pointer sits on
                    // the oldest sample; otherwise the oldest is at entry 0.
                    if (w_stateNext == ST_DONE) begin
                        w_rptrNext = (w_fillNext == FILL_FULL) ? w_wptrNext : '0;
                    end
                end
                ST_DONE: begin
                    if (i_arm) begin
                        w_wptrNext  = '0;
                        w_rptrNext  = '0;
                        w_fillNext  = '0;
                        w_stateNext = i_mode ? ST_STREAM : ST_ARMED;
                    end else begin
                        if ((r_fill != '0) && i_read_ready) begin
                            w_rptrNext = r_rptr + PTR_ONE;
                            w_fillNext = r_fill - FILL_ONE;
                        end
                        if (w_fillNext == '0) begin
                            w_stateNext = ST_IDLE;
                        end
                    end
                end
                ST_STREAM: begin
                    // Pop eligibility uses the registered fill, so a word
                    // written this cycle can never be popped in the same cycle.
                    w_push = i_write_valid && (r_fill != FILL_FULL);
                    w_pop  = i_trace_valid && (r_fill != '0);
                    if (w_push) begin
                        w_memWe    = 1'b1;
                        w_memData  = i_write_data;
                        w_wptrNext = r_wptr + PTR_ONE;
                    end
                    if (w_pop) begin
                        w_rptrNext     = r_rptr + PTR_ONE;
                        w_traceNext    = w_memRdData;
                        w_popValidNext = 1'b1;
                    end
                    if (w_push && !w_pop) begin
                        w_fillNext = r_fill + FILL_ONE;
                    end else if (!w_push && w_pop) begin
                        w_fillNext = r_fill - FILL_ONE;
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fill     <= '0;
            r_dcnt     <= '0;
            r_traceOut <= '0;
            r_popValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_wptr     <= w_wptrNext;
            r_rptr     <= w_rptrNext;
            r_fill     <= w_fillNext;
            r_dcnt     <= w_dcntNext;
            r_traceOut <= w_traceNext;
            r_popValid <= w_popValidNext;
        end
    end

    // Sample memory; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_memWe) begin
            r_mem[r_wptr] <= w_memData;
        end
    end

    assign o_trace       = r_traceOut;
    assign o_trig        = (r_state == ST_DONE) || r_popValid;
    assign o_read_valid  = (r_state == ST_DONE) && (r_fill != '0);
    assign o_read_data   = w_memRdData;
    assign o_write_ready = (r_state == ST_STREAM) && (r_fill != FILL_FULL);
    assign o_fill        = r_fill;

endmodule

// File: tb/tb_stb_trace_core.sv
// tb_stb_trace_core
// Scoreboard bench for stb_trace_core (DEPTH=8, TRACE_WIDTH=8). Stimulus
// tasks keep a queue-based model of captured samples / FIFO contents and
// push expected output words; a negedge monitor pops and compares whenever
// the DUT presents readout data or a popped stream word.
module tb_stb_trace_core;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic          arm = 1'b0;
    logic          disarm = 1'b0;
    logic [AW-1:0] trigDelay = '0;
    logic          traceValid = 1'b0;
    logic [W-1:0]  traceIn = '0;
    logic          trig = 1'b0;
    logic [W-1:0]  traceOut;
    logic          trigOut;
    logic          readReady = 1'b0;
    logic          readValid;
    logic [W-1:0]  readData;
    logic          writeValid = 1'b0;
    logic          writeReady;
    logic [W-1:0]  writeData = '0;
    logic [AW:0]   fill;

    int nCompared = 0;
    int nMismatched = 0;
    logic [W-1:0] sbRead[$];
    logic [W-1:0] sbStream[$];
    logic [W-1:0] fifoM[$];
    bit tbStream = 1'b0;

    stb_trace_core #(.TRACE_WIDTH(W), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_arm(arm),
        .i_disarm(disarm), .i_trig_delay(trigDelay),
        .i_trace_valid(traceValid), .i_trace(traceIn), .i_trig(trig),
        .o_trace(traceOut), .o_trig(trigOut), .i_read_ready(readReady),
        .o_read_valid(readValid), .o_read_data(readData),
        .i_write_valid(writeValid), .o_write_ready(writeReady),
        .i_write_data(writeData), .o_fill(fill)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every input for one cycle, then advance past the next edge
    task automatic applyStimulus(input logic a, input logic m, input logic dis,
                                 input logic tv, input logic [W-1:0] td, input logic tg,
                                 input logic [AW-1:0] dly, input logic rr,
                                 input logic wv, input logic [W-1:0] wd);
        arm = a; mode = m; disarm = dis; traceValid = tv; traceIn = td;
        trig = tg; trigDelay = dly; readReady = rr; writeValid = wv; writeData = wd;
        tick();
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, 0, '0);
    endtask

    // Monitor: compares readout words and popped stream words with the scoreboard
    always @(negedge clk) begin
        if (readValid) begin
            if (sbRead.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL read_unexpected: got 0x%0h, expected no word at %0t", readData, $time);
            end else begin
                checkOutput("read_data", readData, sbRead[0]);
                if (readReady) void'(sbRead.pop_front());
            end
        end
        if (tbStream && trigOut) begin
            if (sbStream.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL stream_unexpected: got 0x%0h, expected no word at %0t", traceOut, $time);
            end else begin
                checkOutput("stream_data", traceOut, sbStream.pop_front());
            end
        end
    end

    // One trace capture + readout. readyPat: 0 always, 1 = 1,0,0,1 pattern, 2 random
    task automatic runTrace(input int nPre, input int delay, input int validPct,
                            input bit seqData, input int readyPat);
        logic [W-1:0] hist[$];
        bit trg = 0;
        bit done = 0;
        int rem = 0;
        int keep;
        int budget = 0;
        logic rr;
        applyStimulus(1, 0, 0, 0, '0, 1, AW'(delay), 0, 0, '0);
        checkOutput("fill_after_arm", fill, 0);
        checkOutput("trig_after_arm", trigOut, 0);
        for (int i = 0; i < 300 && !done; i++) begin
            logic v;
            logic t;
            logic [W-1:0] d;
            d = seqData ? W'(i) : W'($urandom);
            t = (i == nPre);
            v = seqData ? 1'b1 : ($urandom_range(99) < validPct);
            if (v) hist.push_back(d);
            if (t) begin
                trg = 1;
                if (delay == 0) done = 1;
                else rem = delay;
            end else if (trg && v) begin
                rem--;
                if (rem == 0) done = 1;
            end
            applyStimulus(0, 0, 0, v, d, t, AW'(delay), 0, 0, '0);
            checkOutput("trace_daisy", traceOut, d);
            checkOutput("trig_capture", trigOut, done);
        end
        keep = (hist.size() < D) ? hist.size() : D;
        checkOutput("fill_after_capture", fill, keep);
        for (int k = hist.size() - keep; k < hist.size(); k++) sbRead.push_back(hist[k]);
        while (sbRead.size() > 0 && budget < 200) begin
            case (readyPat)
                0: rr = 1'b1;
                1: rr = ((budget % 4) == 0) || ((budget % 4) == 3);
                default: rr = 1'($urandom);
            endcase
            applyStimulus(0, 0, 0, 1'($urandom), W'($urandom), 1'($urandom), '0, rr, 0, '0);
            budget++;
        end
        checkOutput("readout_drained", sbRead.size(), 0);
        sbRead = {};
        applyIdle();
        checkOutput("read_valid_end", readValid, 0);
        checkOutput("fill_end", fill, 0);
        checkOutput("trig_end", trigOut, 0);
    endtask

    // One stream-mode cycle checked against the FIFO model
    task automatic streamCycle(input logic wv, input logic [W-1:0] wd, input logic tv);
        bit push;
        bit pop;
        checkOutput("write_ready", writeReady, fifoM.size() < D);
        checkOutput("stream_fill", fill, fifoM.size());
        push = wv && (fifoM.size() < D);
        pop  = tv && (fifoM.size() > 0);
        if (pop) sbStream.push_back(fifoM.pop_front());
        if (push) fifoM.push_back(wd);
        applyStimulus(0, 0, 0, tv, W'($urandom), 0, '0, 0, wv, wd);
        checkOutput("stream_trig", trigOut, pop);
    endtask

    initial begin
        // Reset held for three cycles with trigger and samples toggling
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 0, 0, 1, 8'h55, 1, 3'd0, 1, 1, 8'h33);
            checkOutput("rst_trace", traceOut, 0);
            checkOutput("rst_trig", trigOut, 0);
            checkOutput("rst_read_valid", readValid, 0);
            checkOutput("rst_write_ready", writeReady, 0);
            checkOutput("rst_fill", fill, 0);
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 8'h12, 1, 3'd0, 1, 1, 8'h34);
        checkOutput("idle_trig_ignored", trigOut, 0);
        checkOutput("idle_fill", fill, 0);
        checkOutput("idle_write_ready", writeReady, 0);

        // Wrap capture, partial fill, backpressure
        runTrace(12, 3, 100, 1, 0);
        runTrace(2, 0, 100, 1, 0);
        runTrace(12, 3, 100, 1, 1);

        // Disarm during POST with two post-trigger samples outstanding
        applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, W'(i), i == 3, 3'd4, 0, 0, '0);
        checkOutput("post_fill", fill, 6);
        checkOutput("post_trig", trigOut, 0);
        applyStimulus(0, 0, 1, 1, 8'h77, 0, 3'd4, 1, 1, 8'h11);
        checkOutput("disarm_fill", fill, 0);
        checkOutput("disarm_trig", trigOut, 0);
        checkOutput("disarm_read_valid", readValid, 0);
        applyStimulus(0, 0, 0, 1, 8'h78, 1, 3'd0, 1, 0, '0);
        checkOutput("disarm_trig_ignored", trigOut, 0);

        // Stream mode: fill to full, overflow refused, drain to empty
        applyStimulus(1, 1, 0, 0, '0, 0, '0, 0, 0, '0);
        tbStream = 1'b1;
        fifoM = {};
        for (int i = 0; i < 9; i++) streamCycle(1, W'(8'hA0 + i), 0);
        for (int i = 0; i < 9; i++) streamCycle(0, '0, 1);
        // Simultaneous push and pop at fill 4
        for (int i = 0; i < 4; i++) streamCycle(1, W'($urandom), 0);
        streamCycle(1, W'($urandom), 1);
        streamCycle(0, '0, 0);
        // Random traffic, then drain
        for (int i = 0; i < 200; i++) streamCycle($urandom_range(99) < 60, W'($urandom), $urandom_range(99) < 50);
        for (int i = 0; i < D + 1; i++) streamCycle(0, '0, 1);
        applyStimulus(0, 0, 1, 1, '0, 0, '0, 0, 1, 8'hEE);
        checkOutput("stream_disarm_fill", fill, 0);
        checkOutput("stream_disarm_write_ready", writeReady, 0);
        checkOutput("stream_disarm_trig", trigOut, 0);
        tbStream = 1'b0;
        fifoM = {};
        checkOutput("stream_sb_empty", sbStream.size(), 0);

        // Randomized captures
        for (int r = 0; r < 6; r++) runTrace($urandom_range(20), $urandom_range(7), 70, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        nMismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
